text_line_renderer: RTL and testbench

- Pixel-pipeline stage directly upstream of the character-glyph ROM in the VGA text path.
- Holds a one-line text buffer of ASCII codes and takes video timing counters (hc, vc, de).
- Drives the glyph ROM address (char_sel, coor_x, coor_y) and takes back its single combinational pixel bit.
- Produces timing-aligned RGB and a delayed data-enable for the display output stage.

---
 rtl/text_line_renderer_if.sv | 31 +++
 rtl/text_line_renderer.sv | 114 +++++++++++
 tb/tb_text_line_renderer.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/text_line_renderer_if.sv
// Signal bundle for text_line_renderer: video timing in, buffer writes in,
// glyph-ROM address out / dot in, and the aligned colour output.
interface text_line_renderer_if #(
  parameter int unsigned N_CHARS = 16
);
  localparam int unsigned AW = $clog2(N_CHARS);

  logic [10:0]   hc;
  logic [10:0]   vc;
  logic          de;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [7:0]    wr_data;
  logic          wr_clear;
  logic [7:0]    char_sel;
  logic [2:0]    coor_x;
  logic [2:0]    coor_y;
  logic          pixel;
  logic [11:0]   rgb;
  logic          de_out;

  modport master (
    output hc, vc, de, wr_en, wr_addr, wr_data, wr_clear, pixel,
    input  char_sel, coor_x, coor_y, rgb, de_out
  );

  modport slave (
    input  hc, vc, de, wr_en, wr_addr, wr_data, wr_clear, pixel,
    output char_sel, coor_x, coor_y, rgb, de_out
  );
endinterface

// File: rtl/text_line_renderer.sv
// Renders a one-line ASCII buffer into a screen window: stage 1 addresses the
// glyph ROM, stage 2 turns the returned dot into a colour aligned with de_out.
module text_line_renderer #(
  parameter int unsigned N_CHARS = 16,
  parameter int unsigned X0      = 0,
  parameter int unsigned Y0      = 0,
  parameter int unsigned SCALE   = 2,
  parameter logic [11:0] FG      = 12'hFFF,
  parameter logic [11:0] BG      = 12'h000
) (
  input logic                  clk,
  input logic                  rst,
  text_line_renderer_if.slave  bus
);

  localparam int unsigned AW    = $clog2(N_CHARS);
  localparam int unsigned CS    = 3 + SCALE;
  localparam int unsigned WIN_W = N_CHARS << CS;
  localparam int unsigned WIN_H = 1 << CS;
  localparam logic [7:0]  SPACE = 8'd32;

  logic [7:0]    text_q [N_CHARS];
  logic [7:0]    text_d [N_CHARS];

  logic [10:0]   rx, ry;
  logic [AW-1:0] cell_idx;
  logic [2:0]    gx, gy;
  logic          in_win;
  logic [7:0]    rd_char;

  logic [7:0]    char_sel_q, char_sel_d;
  logic [2:0]    coor_x_q, coor_x_d;
  logic [2:0]    coor_y_q, coor_y_d;
  logic          in_win_s1_q, in_win_s1_d;
  logic          blank_s1_q, blank_s1_d;
  logic          de_s1_q, de_s1_d;
  logic [11:0]   rgb_q, rgb_d;
  logic          de_out_q, de_out_d;

  always_comb begin
    for (int unsigned i = 0; i < N_CHARS; i++) text_d[i] = text_q[i];
    if (bus.wr_clear) begin
      for (int unsigned i = 0; i < N_CHARS; i++) text_d[i] = SPACE;
    end else if (bus.wr_en && (32'(bus.wr_addr) < N_CHARS)) begin
      text_d[bus.wr_addr] = bus.wr_data;
    end
  end

  // Unsigned wrap makes hc < X0 / vc < Y0 land far outside the window.
  always_comb begin
    rx       = bus.hc - 11'(X0);
    ry       = bus.vc - 11'(Y0);
    cell_idx = AW'(rx >> CS);
    gx       = 3'(rx >> SCALE);
    gy       = 3'(ry >> SCALE);
    in_win   = (32'(rx) < WIN_W) && (32'(ry) < WIN_H);
    rd_char  = text_q[cell_idx];
  end

  always_comb begin
    char_sel_d  = SPACE;
    coor_x_d    = '0;
    coor_y_d    = '0;
    in_win_s1_d = in_win;
    blank_s1_d  = (gx >= 3'd5) || (rd_char == SPACE);
    de_s1_d     = bus.de;
    if (in_win) begin
      char_sel_d = rd_char;
      coor_x_d   = gx;
      coor_y_d   = gy;
    end
  end

  // Space is forced blank because the ROM draws unknown codes as a dot.
  always_comb begin
    rgb_d    = '0;
    de_out_d = de_s1_q;
    if (de_s1_q) begin
      if (!in_win_s1_q || blank_s1_q) rgb_d = BG;
      else                            rgb_d = bus.pixel ? FG : BG;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < N_CHARS; i++) text_q[i] <= SPACE;
      char_sel_q  <= SPACE;
      coor_x_q    <= '0;
      coor_y_q    <= '0;
      in_win_s1_q <= 1'b0;
      blank_s1_q  <= 1'b0;
      de_s1_q     <= 1'b0;
      rgb_q       <= '0;
      de_out_q    <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < N_CHARS; i++) text_q[i] <= text_d[i];
      char_sel_q  <= char_sel_d;
      coor_x_q    <= coor_x_d;
      coor_y_q    <= coor_y_d;
      in_win_s1_q <= in_win_s1_d;
      blank_s1_q  <= blank_s1_d;
      de_s1_q     <= de_s1_d;
      rgb_q       <= rgb_d;
      de_out_q    <= de_out_d;
    end
  end

  assign bus.char_sel = char_sel_q;
  assign bus.coor_x   = coor_x_q;
  assign bus.coor_y   = coor_y_q;
  assign bus.rgb      = rgb_q;
  assign bus.de_out   = de_out_q;

endmodule

// File: tb/tb_text_line_renderer.sv
// Directed bench for text_line_renderer with a small glyph-ROM model driving pixel.
module tb_text_line_renderer;

  localparam logic [11:0] FG = 12'hF80;
  localparam logic [11:0] BG = 12'h00F;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  text_line_renderer_if #(.N_CHARS(16)) bus ();

  text_line_renderer #(
    .N_CHARS(16), .X0(0), .Y0(0), .SCALE(2), .FG(FG), .BG(BG)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Gap columns and space return 1 so missing blanking shows up as FG.
  function automatic logic [4:0] glyph_row(input logic [7:0] ch, input logic [2:0] y);
    if (y == 3'd7) return 5'b00000;
    case (ch)
      8'd65:   return (y == 3'd0) ? 5'b01110 : (y == 3'd3) ? 5'b11111 : 5'b10001;
      8'd76:   return (y == 3'd6) ? 5'b11111 : 5'b10000;
      8'd69:   return (y == 3'd0 || y == 3'd6) ? 5'b11111 : (y == 3'd3) ? 5'b11110 : 5'b10000;
      default: return 5'b00100;
    endcase
  endfunction

  function automatic logic rom_pix(input logic [7:0] ch, input logic [2:0] x, input logic [2:0] y);
    logic [4:0] row;
    row = glyph_row(ch, y);
    if (x >= 3'd5) return 1'b1;
    return row[3'd4 - x];
  endfunction

  always_comb bus.pixel = rom_pix(bus.char_sel, bus.coor_x, bus.coor_y);

  int total = 0;
  int bad   = 0;
  logic        have_prev;
  logic [11:0] prev_rgb;
  logic        prev_de;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One pixel per clock: checks ROM address of this input (1 clk) and the
  // colour/de_out of the previous input (2 clk).
  task automatic pix(input int h, input int v, input logic d, input logic [11:0] er,
                     input logic [7:0] ec, input int ex, input int ey);
    bus.hc = 11'(h);
    bus.vc = 11'(v);
    bus.de = d;
    @(posedge clk); #1;
    if (have_prev) begin
      chk("rgb", 32'(bus.rgb), 32'(prev_rgb));
      chk("de_out", 32'(bus.de_out), 32'(prev_de));
    end
    chk("char_sel", 32'(bus.char_sel), 32'(ec));
    chk("coor_x", 32'(bus.coor_x), 32'(ex));
    chk("coor_y", 32'(bus.coor_y), 32'(ey));
    prev_rgb  = er;
    prev_de   = d;
    have_prev = 1'b1;
  endtask

  task automatic flush();
    pix(700, 0, 1'b0, 12'h000, 8'd32, 0, 0);
  endtask

  task automatic wr(input int a, input logic [7:0] dat);
    bus.wr_en   = 1'b1;
    bus.wr_addr = 4'(a);
    bus.wr_data = dat;
    @(posedge clk); #1;
    bus.wr_en   = 1'b0;
    have_prev   = 1'b0;
  endtask

  initial begin
    rst          = 1'b1;
    bus.hc       = '0;
    bus.vc       = '0;
    bus.de       = 1'b0;
    bus.wr_en    = 1'b0;
    bus.wr_addr  = '0;
    bus.wr_data  = '0;
    bus.wr_clear = 1'b0;
    have_prev    = 1'b0;
    prev_rgb     = '0;
    prev_de      = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rgb", 32'(bus.rgb), 32'h0);
    chk("rst_de_out", 32'(bus.de_out), 32'h0);
    chk("rst_char_sel", 32'(bus.char_sel), 32'd32);
    chk("rst_coor_x", 32'(bus.coor_x), 32'h0);
    chk("rst_coor_y", 32'(bus.coor_y), 32'h0);
    rst = 1'b0;

    // Empty buffer sweep: BG inside active video, 0 where de is low
    for (int v = 0; v < 32; v++) begin
      for (int h = 0; h < 640; h++) begin
        pix(h, v, (h < 600), (h < 600) ? BG : 12'h000, 8'd32,
            (h < 512) ? ((h >> 2) & 7) : 0, (h < 512) ? ((v >> 2) & 7) : 0);
      end
    end
    flush();

    // 'A' in cell 0, top row 01110
    wr(0, 8'd65);
    for (int h = 0; h < 32; h++)
      pix(h, 0, 1'b1, (h >= 4 && h < 16) ? FG : BG, 8'd65, (h >> 2) & 7, 0);
    flush();

    // 'L' in cell 1, row 6 = 11111
    wr(1, 8'd76);
    for (int h = 32; h < 64; h++)
      pix(h, 24, 1'b1, (h < 52) ? FG : BG, 8'd76, (h >> 2) & 7, 6);
    flush();

    // Same-cycle write to the cell being read returns the old value
    bus.wr_en   = 1'b1;
    bus.wr_addr = 4'd3;
    bus.wr_data = 8'd69;
    pix(96, 0, 1'b1, BG, 8'd32, 0, 0);
    bus.wr_en   = 1'b0;
    pix(96, 0, 1'b1, FG, 8'd69, 0, 0);
    flush();

    // Clear beats a simultaneous write
    bus.wr_clear = 1'b1;
    bus.wr_en    = 1'b1;
    bus.wr_addr  = 4'd4;
    bus.wr_data  = 8'd69;
    flush();
    bus.wr_clear = 1'b0;
    bus.wr_en    = 1'b0;
    for (int c = 0; c < 5; c++)
      pix(c * 32 + 4, 0, 1'b1, BG, 8'd32, 1, 0);
    flush();

    // de low inside window, and window edges
    wr(0, 8'd65);
    pix(4, 0, 1'b0, 12'h000, 8'd65, 1, 0);
    pix(512, 0, 1'b1, BG, 8'd32, 0, 0);
    pix(4, 32, 1'b1, BG, 8'd32, 0, 0);
    pix(511, 31, 1'b1, BG, 8'd32, 7, 7);
    pix(4, 0, 1'b1, FG, 8'd65, 1, 0);
    flush();

    // Reset mid-line with text loaded
    wr(1, 8'd76);
    pix(36, 24, 1'b1, FG, 8'd76, 1, 6);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_rgb", 32'(bus.rgb), 32'h0);
    chk("midrst_de_out", 32'(bus.de_out), 32'h0);
    chk("midrst_char_sel", 32'(bus.char_sel), 32'd32);
    rst       = 1'b0;
    have_prev = 1'b1;
    prev_rgb  = 12'h000;
    prev_de   = 1'b0;
    pix(36, 24, 1'b1, BG, 8'd32, 1, 6);
    pix(36, 24, 1'b1, BG, 8'd32, 1, 6);
    pix(4, 0, 1'b1, BG, 8'd32, 1, 0);
    flush();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
